mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the execute stage. It consumes the RS/RT operand pair produced by the register file and computes MULT, MULTU, DIV and DIVU into dedicated HI/LO registers. MFHI and MFLO read those registers, and MTHI and MTLO write them. Each operation is multi-cycle, and a busy/done handshake lets the control path stall dependent instructions.

---
 rtl/mult_div_unit.sv | 134 +++++++++++++
 tb/tb_mult_div_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// ============================================================================
// mult_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_res;
  logic        neg_rem;
  logic [31:0] b_mag;
  logic [31:0] acc_hi;
  logic [31:0] acc_lo;

  logic        op_signed;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign op_signed = ~op[0];
  assign a_abs     = (op_signed && rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign b_abs     = (op_signed && rt_data[31]) ? (32'd0 - rt_data) : rt_data;

  // acc_hi/acc_lo hold {product high, multiplier} for MULT and {remainder, dividend} for DIV
  assign add_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_mag} : 33'd0);
  assign trial    = {acc_hi, acc_lo[31]} - {1'b0, b_mag};
  assign prod_fix = neg_res ? (64'd0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
  assign quot_fix = neg_res ? (32'd0 - acc_lo) : acc_lo;
  assign rem_fix  = neg_rem ? (32'd0 - acc_hi) : acc_hi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      b_mag       <= 32'd0;
      acc_hi      <= 32'd0;
      acc_lo      <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
    end else begin
      done <= 1'b0;
      if (!busy && hi_we) hi <= wdata;
      if (!busy && lo_we) lo <= wdata;
      case (state)
        IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_res <= op_signed && (rs_data[31] ^ rt_data[31]);
            neg_rem <= op_signed && rs_data[31];
            b_mag   <= b_abs;
            acc_hi  <= 32'd0;
            acc_lo  <= a_abs;
            cnt     <= 5'd0;
            busy    <= 1'b1;
            if (op[1] && (rt_data == 32'd0)) begin
              div_by_zero <= 1'b1;
              state       <= FIX;
            end else begin
              div_by_zero <= 1'b0;
              state       <= RUN;
            end
          end
        end
        RUN: begin
          if (is_div) begin
            if (!trial[32]) begin
              acc_hi <= trial[31:0];
              acc_lo <= {acc_lo[30:0], 1'b1};
            end else begin
              acc_hi <= {acc_hi[30:0], acc_lo[31]};
              acc_lo <= {acc_lo[30:0], 1'b0};
            end
          end else begin
            acc_hi <= add_sum[32:1];
            acc_lo <= {add_sum[0], acc_lo[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          // a divide-by-zero arrives here straight from IDLE and leaves HI/LO alone
          if (!div_by_zero) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              hi <= prod_fix[63:32];
              lo <= prod_fix[31:0];
            end
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          passed = 0;
  int          total  = 0;

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .hi_we(hi_we), .lo_we(lo_we),
    .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference model: results computed at the start edge and queued.
  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sd, q, r;
    e.dbz = 1'b0;
    e.lat = 33;
    case (o)
      2'b00: begin
        p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32]; e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b1; e.lat = 1;
        end else if (o == 2'b10) begin
          sa = longint'($signed(a));
          sd = longint'($signed(b));
          q = sa / sd;
          r = sa % sd;
          e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
    endcase
    sb.push_back(e);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clock);
    start = 1'b0; rs_data = 32'hDEADBEEF; rt_data = 32'hDEADBEEF; op = ~o;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_after_start", 64'(done), 64'd0);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    int   n = 0;
    int   busy_low = 0;
    e = sb.pop_front();
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
      if (!done && !busy) busy_low++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'(e.lat));
    check({tag, "_busy_during"}, 64'(busy_low), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "_hi"}, 64'(hi), 64'(e.hi));
    check({tag, "_lo"}, 64'(lo), 64'(e.lo));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
    m_hi = e.hi;
    m_lo = e.lo;
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = 32'd0; rt_data = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
    repeat (3) @(negedge clock);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    reset = 1'b0;

    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_done("multu_max");
    start_op(2'b00, 32'hFFFFFFFD, 32'd7);        wait_done("mult_neg");
    start_op(2'b10, 32'hFFFFFFF9, 32'd2);        wait_done("div_neg");
    start_op(2'b10, 32'h80000000, 32'hFFFFFFFF); wait_done("div_ovf");

    @(negedge clock);
    hi_we = 1'b1; wdata = 32'h12345678;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hCAFEF00D;
    @(negedge clock);
    lo_we = 1'b0;
    check("mthi", 64'(hi), 64'h12345678);
    check("mtlo", 64'(lo), 64'hCAFEF00D);
    m_hi = 32'h12345678; m_lo = 32'hCAFEF00D;
    start_op(2'b11, 32'd5, 32'd0);               wait_done("divu_zero");
    start_op(2'b01, 32'd2, 32'd3);               wait_done("multu_2x3");

    // Ignored start / MTHI while busy, then asynchronous reset mid-operation
    start_op(2'b01, 32'd5, 32'd5);
    done_seen = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (done) done_seen++;
      start = (c == 5);
      if (c == 5) begin op = 2'b00; rs_data = 32'd9; rt_data = 32'd9; end
      hi_we = (c == 10);
      wdata = 32'hDEADBEEF;
    end
    start = 1'b0; hi_we = 1'b0;
    check("busy_hold", 64'(busy), 64'd1);
    check("mthi_ignored", 64'(hi), 64'(m_hi));
    #2 reset = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    void'(sb.pop_front());
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    check("no_done_pulse", 64'(done_seen), 64'd0);
    reset = 1'b0;
    start_op(2'b01, 32'd5, 32'd5);               wait_done("multu_5x5");

    // Back-to-back: second start issued during the done cycle
    start_op(2'b11, 32'd100, 32'd7);             wait_done("divu_100_7");
    start_op(2'b01, 32'd4, 32'd4);               wait_done("multu_b2b");

    @(negedge clock);
    check("done_one_cycle", 64'(done), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
